// File: rtl/shift194_seq.sv
// shift194_seq: command sequencer for an external DM74LS194 4-bit universal
// shift register. One command is taken at a time: clear, parallel load, or a
// shift/rotate by 0..7 places. The register's outputs are fed back so that
// rotates can recirculate the end bit, and a snapshot is taken on completion.
//
// Handshake: start is sampled only while the block is IDLE (busy=0). The edge
// that samples start=1 also captures op/cnt/din/sin. Starts seen while busy
// are dropped. Every accepted command ends with exactly one done pulse (err
// alongside it for an illegal op), except one aborted by rst.
module shift194_seq (
    input  logic       clk,
    input  logic       rst,
    input  logic       start,
    input  logic [2:0] op,
    input  logic [2:0] cnt,
    input  logic [3:0] din,
    input  logic       sin,
    input  logic       QA,
    input  logic       QB,
    input  logic       QC,
    input  logic       QD,
    output logic       S1,
    output logic       S0,
    output logic       SR,
    output logic       SL,
    output logic       A,
    output logic       B,
    output logic       C,
    output logic       D,
    output logic       CR,
    output logic       busy,
    output logic       done,
    output logic       err,
    output logic [3:0] q,
    output logic [2:0] dbg_state
);

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        CLR   = 3'd1,
        LOAD  = 3'd2,
        SHIFT = 3'd3,
        DONE  = 3'd4
    } state_t;

    localparam logic [2:0] OP_CLEAR = 3'b000;
    localparam logic [2:0] OP_LOAD  = 3'b001;
    localparam logic [2:0] OP_SHR   = 3'b010;
    localparam logic [2:0] OP_SHL   = 3'b011;
    localparam logic [2:0] OP_ROR   = 3'b100;
    localparam logic [2:0] OP_ROL   = 3'b101;

    state_t     state;
    state_t     nxt;
    logic [2:0] op_r;
    logic [2:0] cnt_r;
    logic [3:0] din_r;
    logic       sin_r;

    // Command fields as they will be after this edge (fresh on accept).
    logic       accept;
    logic [2:0] op_n;
    logic [3:0] din_n;
    logic       sin_n;

    // Registered control bits; rotates add the live feedback bit on top.
    logic       cr_q;
    logic       sr_q;
    logic       sl_q;
    logic       ror_q;
    logic       rol_q;

    // Next-state decode plus the command fields that will be in effect.
    always_comb begin
        accept = (state == IDLE) && start;
        op_n   = accept ? op  : op_r;
        din_n  = accept ? din : din_r;
        sin_n  = accept ? sin : sin_r;
        nxt    = state;
        case (state)
            IDLE: begin
                if (start) begin
                    case (op)
                        OP_CLEAR: nxt = CLR;
                        OP_LOAD:  nxt = LOAD;
                        OP_SHR, OP_SHL, OP_ROR, OP_ROL:
                            nxt = (cnt != 3'd0) ? SHIFT : DONE;
                        default:  nxt = DONE;
                    endcase
                end
            end
            CLR:     nxt = DONE;
            LOAD:    nxt = DONE;
            SHIFT:   nxt = (cnt_r <= 3'd1) ? DONE : SHIFT;
            DONE:    nxt = IDLE;
            default: nxt = IDLE;
        endcase
    end

    // State, command capture, shift counter and registered Moore outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
            op_r  <= 3'd0;
            cnt_r <= 3'd0;
            din_r <= 4'd0;
            sin_r <= 1'b0;
            busy  <= 1'b0;
            done  <= 1'b0;
            err   <= 1'b0;
            S1    <= 1'b0;
            S0    <= 1'b0;
            A     <= 1'b0;
            B     <= 1'b0;
            C     <= 1'b0;
            D     <= 1'b0;
            cr_q  <= 1'b1;
            sr_q  <= 1'b0;
            sl_q  <= 1'b0;
            ror_q <= 1'b0;
            rol_q <= 1'b0;
            q     <= 4'd0;
        end else begin
            state <= nxt;
            if (accept) begin
                op_r  <= op;
                cnt_r <= cnt;
                din_r <= din;
                sin_r <= sin;
            end else if (state == SHIFT && cnt_r != 3'd0) begin
                cnt_r <= cnt_r - 3'd1;
            end
            busy  <= (nxt != IDLE);
            done  <= (nxt == DONE);
            err   <= (nxt == DONE) && (op_n[2:1] == 2'b11);
            S1    <= (nxt == LOAD) ||
                     ((nxt == SHIFT) && (op_n == OP_SHL || op_n == OP_ROL));
            S0    <= (nxt == LOAD) ||
                     ((nxt == SHIFT) && (op_n == OP_SHR || op_n == OP_ROR));
            {A, B, C, D} <= (nxt == LOAD) ? din_n : 4'd0;
            cr_q  <= (nxt != CLR);
            sr_q  <= (nxt == SHIFT) && (op_n == OP_SHR) && sin_n;
            sl_q  <= (nxt == SHIFT) && (op_n == OP_SHL) && sin_n;
            ror_q <= (nxt == SHIFT) && (op_n == OP_ROR);
            rol_q <= (nxt == SHIFT) && (op_n == OP_ROL);
            if (state == DONE) begin
                q <= {QA, QB, QC, QD};
            end
        end
    end

    // Rotates feed the end bit straight back; rst clears the register at once.
    assign SR        = sr_q | (ror_q & QD);
    assign SL        = sl_q | (rol_q & QA);
    assign CR        = cr_q & ~rst;
    assign dbg_state = state;

endmodule

// File: doc/shift194_seq.md
SHIFT194_SEQ -- requirements
Module: shift194_seq

Interface
REQ-001 The block SHALL use one clock and a synchronous, active-high reset: clk is the clock, rst is the reset, and all state changes on the clk rising edge.
REQ-002 Port clk, input, 1 bit: system clock, shared with the controlled DM74LS194 shift register.
REQ-003 Port rst, input, 1 bit: synchronous active-high reset.
REQ-004 Port start, input, 1 bit: command request, sampled only in IDLE.
REQ-005 Port op, input, 3 bits: command code.
- 000 CLEAR; 001 LOAD; 010 SHR (shift right, fill sin); 011 SHL (shift left, fill sin); 100 ROR (rotate right); 101 ROL (rotate left); 110/111 illegal.
REQ-006 Port cnt, input, 3 bits: shift/rotate count, 0..7.
REQ-007 Port din, input, 4 bits: load data; din[3] maps to A, din[2] to B, din[1] to C, din[0] to D.
REQ-008 Port sin, input, 1 bit: serial fill bit for SHR/SHL.
REQ-009 Ports QA, QB, QC, QD, input, 1 bit each: feedback from the register outputs.
REQ-010 Ports S1, S0, SR, SL, A, B, C, D, CR, output, 1 bit each: register controls; CR is active-low clear.
REQ-011 Port busy, output, 1 bit: high in every state except IDLE.
REQ-012 Port done, output, 1 bit: one-cycle completion pulse.
REQ-013 Port err, output, 1 bit: one-cycle pulse with done for an illegal op.
REQ-014 Port q, output, 4 bits: registered snapshot {QA,QB,QC,QD}.

Function
REQ-015 The FSM SHALL have the states IDLE, CLR, LOAD, SHIFT and DONE; outputs are Moore-decoded from registered state, except SR and SL in rotate mode.
REQ-016 In IDLE with start=1, the block SHALL capture op, cnt, din and sin at that edge (E0); start while busy SHALL be ignored.
REQ-017 Transitions from IDLE SHALL be:
- CLEAR to CLR; LOAD to LOAD.
- Shift/rotate with cnt>0 to SHIFT; with cnt=0 to DONE.
- Illegal op to DONE with err set.
REQ-018 CLR and LOAD SHALL each last exactly 1 cycle, then go to DONE.
REQ-019 SHIFT SHALL last exactly cnt cycles, tracked by a 3-bit down-counter, then go to DONE.
REQ-020 DONE SHALL last 1 cycle with done=1, then go to IDLE; start may be accepted on the edge leaving DONE+1, i.e. in IDLE.
REQ-021 Mode outputs {S1,S0} SHALL be: 11 in LOAD; 01 in SHIFT for SHR/ROR; 10 in SHIFT for SHL/ROL; 00 in all other states.
REQ-022 CR SHALL be 0 in CLR or while rst=1, and 1 otherwise.
REQ-023 A–D SHALL equal the captured din in LOAD and 0 otherwise.
REQ-024 In SHIFT, SR SHALL be captured sin for SHR and QD for ROR; SL SHALL be captured sin for SHL and QA for ROL; otherwise SR=SL=0.
REQ-025 q SHALL load {QA,QB,QC,QD} on the edge ending DONE and hold otherwise.
REQ-026 Latency: done SHALL be high in the cycle following edge E(N), where N=1 for CLEAR/LOAD, N=cnt for shifts and N=0 for cnt=0 or illegal ops.
REQ-027 err SHALL be high only in a DONE cycle reached from an illegal op.
REQ-028 The register SHALL see no mode other than 00 and no CR pulse for an illegal op or cnt=0.

Reset
REQ-029 rst=1 SHALL force state IDLE, counter 0, busy=0, done=0, err=0, q=0000, S1S0=00, SR=SL=0, A–D=0 and CR=0 on the next edge.
REQ-030 rst asserted mid-SHIFT SHALL abort the command at that edge, with no done pulse and the register cleared via CR.
REQ-031 After rst deasserts, the block SHALL accept start in the first IDLE cycle.

Verification
REQ-032 rst for 2 cycles, then idle -> QA..QD=0000, busy=0, CR=1, q=0000.
REQ-033 start, op=001, din=1010 -> one cycle at S1S0=11, done in the 2nd cycle after start edge, q=1010.
REQ-034 From 1010: op=010, cnt=2, sin=0 -> 2 cycles at S1S0=01, QA..QD=0010, done in cycle after E2, q=0010.
REQ-035 From 1010: op=101, cnt=1 -> SL=QA=1, QA..QD=0101; then op=100, cnt=4 -> QA..QD=0101 (full rotation), done in cycle after E4.
REQ-036 op=110 -> done=err=1 in the cycle after E0 with S1S0=00 throughout; op=011, cnt=0 -> done in the cycle after E0 with no shift; start pulsed while busy -> ignored.
REQ-037 op=010, cnt=7, rst asserted after 3 shift cycles -> IDLE, no done, QA..QD=0000.
